// File: rtl/gtp_nin_sched.sv
// gtp_nin_sched: GTP transmit scheduler; round-robin over 3 XBI VC buffers with per-VC credits and a CRC16 trailer word.
// Build option GTP_NIN_SCHED_PRIO_EN: VC2 gets strict priority, VC0/VC1 share a round-robin.
module gtp_nin_sched #(
    parameter int CREDITS = 2,
    parameter int CNT_W   = 2
) (
    input  logic        clk_gtp,
    input  logic        rst_gtp_n,
    input  logic [2:0]  i_xbi_nin_ready,
    input  logic [17:0] i_xbi_nin_len,
    output logic [2:0]  o_xbi_nin_deq,
    output logic [5:0]  o_xbi_nin_offset,
    output logic        o_xbi_nin_eop,
    input  logic [15:0] i_xbi_nin_data,
    input  logic        i_gtp_out_hold,
    output logic        o_gtp_out_valid,
    output logic        o_gtp_out_sop,
    output logic        o_gtp_out_eop,
    output logic [15:0] o_gtp_out_data,
    input  logic [2:0]  i_gtp_out_credit,
    output logic        o_error_credit,
    output logic        o_error_len
);

    // state | meaning
    // IDLE  | waiting for an eligible VC; grant taken here (also the CRC output cycle)
    // RD    | one XBI read strobe per cycle, offset 0..len-1
    // W1    | last read data returning from XBI
    // W2    | last payload word registered to output, CRC word queued
    typedef enum logic [1:0] {IDLE, RD, W1, W2} state_t;

    state_t           state_q, state_d;
    logic [2:0]       grant_q, grant_d;
    logic [5:0]       len_q, len_d;
    logic [5:0]       off_q, off_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cred_q [3];
    logic [CNT_W-1:0] cred_d [3];
    logic             err_cred_d;

    logic [2:0]       elig;
    logic [2:0]       pick;
    logic [5:0]       req_len;
    logic             grant_en;
    logic             last_rd;

    logic             rd_vld_q, rd_sop_q, rd_last_q;
    logic             crc_pend_q;
    logic [15:0]      crc_q, crc_upd;
    logic             out_vld_q, out_sop_q, out_eop_q;
    logic [15:0]      out_data_q;
    logic             err_cred_q, err_len_q;

    // CRC-16 poly 0x1021, MSB first, no reflection, no final xor; seed 0 per packet
    function automatic logic [15:0] crc16_word(input logic [15:0] crc_in, input logic [15:0] din);
        logic [15:0] c;
        c = crc_in;
        for (int b = 15; b >= 0; b--) begin
            if (c[15] ^ din[b]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    always_comb begin
        for (int v = 0; v < 3; v++) elig[v] = i_xbi_nin_ready[v] && (cred_q[v] != '0);
    end

    always_comb begin
        pick = 3'b000;
`ifdef GTP_NIN_SCHED_PRIO_EN
        if (elig[2])             pick = 3'b100;
        else if (ptr_q == 2'd0)  pick = elig[1] ? 3'b010 : (elig[0] ? 3'b001 : 3'b000);
        else                     pick = elig[0] ? 3'b001 : (elig[1] ? 3'b010 : 3'b000);
`else
        case (ptr_q)
            2'd0:    pick = elig[1] ? 3'b010 : (elig[2] ? 3'b100 : (elig[0] ? 3'b001 : 3'b000));
            2'd1:    pick = elig[2] ? 3'b100 : (elig[0] ? 3'b001 : (elig[1] ? 3'b010 : 3'b000));
            default: pick = elig[0] ? 3'b001 : (elig[1] ? 3'b010 : (elig[2] ? 3'b100 : 3'b000));
        endcase
`endif
    end

    always_comb begin
        req_len = '0;
        case (pick)
            3'b001:  req_len = i_xbi_nin_len[5:0];
            3'b010:  req_len = i_xbi_nin_len[11:6];
            3'b100:  req_len = i_xbi_nin_len[17:12];
            default: req_len = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        len_d    = len_q;
        off_d    = off_q;
        ptr_d    = ptr_q;
        grant_en = 1'b0;
        last_rd  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!i_gtp_out_hold && (pick != 3'b000)) begin
                    grant_en = 1'b1;
                    grant_d  = pick;
                    len_d    = (req_len == '0) ? 6'd1 : req_len;
                    off_d    = '0;
                    state_d  = RD;
`ifdef GTP_NIN_SCHED_PRIO_EN
                    if (!pick[2]) ptr_d = pick[1] ? 2'd1 : 2'd0;
`else
                    ptr_d = pick[2] ? 2'd2 : (pick[1] ? 2'd1 : 2'd0);
`endif
                end
            end
            RD: begin
                last_rd = (off_q == len_q - 6'd1);
                if (last_rd) state_d = W1;
                else         off_d   = off_q + 6'd1;
            end
            W1:      state_d = W2;
            W2:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // a grant and a returned credit on the same VC cancel out
    always_comb begin
        err_cred_d = 1'b0;
        for (int v = 0; v < 3; v++) begin
            cred_d[v] = cred_q[v];
            if (grant_en && pick[v] && !i_gtp_out_credit[v]) begin
                cred_d[v] = cred_q[v] - CNT_W'(1);
            end else if (i_gtp_out_credit[v] && !(grant_en && pick[v])) begin
                if (cred_q[v] == CNT_W'(CREDITS)) err_cred_d = 1'b1;
                else                              cred_d[v] = cred_q[v] + CNT_W'(1);
            end
        end
    end

    assign crc_upd = crc16_word(rd_sop_q ? 16'h0000 : crc_q, i_xbi_nin_data);

    always_ff @(posedge clk_gtp or negedge rst_gtp_n) begin
        if (!rst_gtp_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            len_q      <= '0;
            off_q      <= '0;
            ptr_q      <= 2'd2;
            for (int v = 0; v < 3; v++) cred_q[v] <= CNT_W'(CREDITS);
            rd_vld_q   <= 1'b0;
            rd_sop_q   <= 1'b0;
            rd_last_q  <= 1'b0;
            crc_pend_q <= 1'b0;
            crc_q      <= '0;
            out_vld_q  <= 1'b0;
            out_sop_q  <= 1'b0;
            out_eop_q  <= 1'b0;
            out_data_q <= '0;
            err_cred_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            len_q      <= len_d;
            off_q      <= off_d;
            ptr_q      <= ptr_d;
            for (int v = 0; v < 3; v++) cred_q[v] <= cred_d[v];
            rd_vld_q   <= (state_q == RD);
            rd_sop_q   <= (state_q == RD) && (off_q == '0);
            rd_last_q  <= last_rd;
            crc_pend_q <= rd_vld_q && rd_last_q;
            if (rd_vld_q) crc_q <= crc_upd;
            out_vld_q  <= rd_vld_q || crc_pend_q;
            out_sop_q  <= rd_vld_q && rd_sop_q;
            out_eop_q  <= crc_pend_q;
            out_data_q <= rd_vld_q ? i_xbi_nin_data : (crc_pend_q ? crc_q : 16'h0000);
            err_cred_q <= err_cred_d;
            err_len_q  <= grant_en && (req_len == '0);
        end
    end

    assign o_xbi_nin_deq    = (state_q == RD) ? grant_q : 3'b000;
    assign o_xbi_nin_offset = (state_q == RD) ? off_q : 6'd0;
    assign o_xbi_nin_eop    = last_rd;
    assign o_gtp_out_valid  = out_vld_q;
    assign o_gtp_out_sop    = out_sop_q;
    assign o_gtp_out_eop    = out_eop_q;
    assign o_gtp_out_data   = out_data_q;
    assign o_error_credit   = err_cred_q;
    assign o_error_len      = err_len_q;

endmodule

// File: tb/tb_gtp_nin_sched.sv
// Directed bench for gtp_nin_sched: XBI buffer model, output/strobe logging and hand-derived expectations.
`timescale 1ns/1ps
module tb_gtp_nin_sched;

    logic        clk_gtp = 1'b0;
    logic        rst_gtp_n;
    logic [2:0]  i_xbi_nin_ready;
    logic [17:0] i_xbi_nin_len;
    logic [2:0]  o_xbi_nin_deq;
    logic [5:0]  o_xbi_nin_offset;
    logic        o_xbi_nin_eop;
    logic [15:0] i_xbi_nin_data = 16'h0000;
    logic        i_gtp_out_hold;
    logic        o_gtp_out_valid;
    logic        o_gtp_out_sop;
    logic        o_gtp_out_eop;
    logic [15:0] o_gtp_out_data;
    logic [2:0]  i_gtp_out_credit;
    logic        o_error_credit;
    logic        o_error_len;

    logic [5:0]  len_v [3];
    logic [15:0] mem [3][64];
    assign i_xbi_nin_len = {len_v[2], len_v[1], len_v[0]};

    gtp_nin_sched #(.CREDITS(2), .CNT_W(2)) dut (
        .clk_gtp          (clk_gtp),
        .rst_gtp_n        (rst_gtp_n),
        .i_xbi_nin_ready  (i_xbi_nin_ready),
        .i_xbi_nin_len    (i_xbi_nin_len),
        .o_xbi_nin_deq    (o_xbi_nin_deq),
        .o_xbi_nin_offset (o_xbi_nin_offset),
        .o_xbi_nin_eop    (o_xbi_nin_eop),
        .i_xbi_nin_data   (i_xbi_nin_data),
        .i_gtp_out_hold   (i_gtp_out_hold),
        .o_gtp_out_valid  (o_gtp_out_valid),
        .o_gtp_out_sop    (o_gtp_out_sop),
        .o_gtp_out_eop    (o_gtp_out_eop),
        .o_gtp_out_data   (o_gtp_out_data),
        .i_gtp_out_credit (i_gtp_out_credit),
        .o_error_credit   (o_error_credit),
        .o_error_len      (o_error_len)
    );

    always #5 clk_gtp = ~clk_gtp;

    int cyc = 0;
    always @(posedge clk_gtp) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct { logic [2:0] deq; logic [5:0] off; logic eop; int cyc; } strb_t;
    typedef struct { logic sop; logic eop; logic [15:0] data; int cyc; } word_t;
    strb_t sq[$];
    word_t wq[$];
    int ecred_n = 0, ecred_cyc = 0, elen_n = 0, elen_cyc = 0;

    always @(negedge clk_gtp) begin
        if (o_xbi_nin_deq != 3'b000)
            sq.push_back('{deq: o_xbi_nin_deq, off: o_xbi_nin_offset, eop: o_xbi_nin_eop, cyc: cyc});
        if (o_gtp_out_valid)
            wq.push_back('{sop: o_gtp_out_sop, eop: o_gtp_out_eop, data: o_gtp_out_data, cyc: cyc});
        if (o_error_credit) begin ecred_n++; ecred_cyc = cyc; end
        if (o_error_len)    begin elen_n++;  elen_cyc  = cyc; end
    end

    function automatic int vc_of(input logic [2:0] d);
        return d[0] ? 0 : (d[1] ? 1 : 2);
    endfunction

    // XBI model: strobe seen in cycle T, data presented during T+1
    logic [2:0] cap_deq;
    logic [5:0] cap_off;
    always begin
        @(negedge clk_gtp);
        cap_deq = o_xbi_nin_deq;
        cap_off = o_xbi_nin_offset;
        @(posedge clk_gtp);
        #1;
        i_xbi_nin_data = (cap_deq != 3'b000) ? mem[vc_of(cap_deq)][cap_off] : 16'hBEEF;
    end

    // reference CRC by long division of the message augmented with 16 zero bits
    function automatic logic [15:0] crc_ref(input int v, input int n);
        logic [15:0] r;
        logic        top, bitv;
        r = 16'h0000;
        for (int k = 0; k <= n; k++) begin
            for (int b = 15; b >= 0; b--) begin
                bitv = (k < n) ? mem[v][k][b] : 1'b0;
                top  = r[15];
                r    = {r[14:0], bitv};
                if (top) r = r ^ 16'h1021;
            end
        end
        return r;
    endfunction

    function automatic int ngrants(input int s0);
        int n = 0;
        for (int i = s0; i < sq.size(); i++) if (sq[i].off == 6'd0) n++;
        return n;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_gtp);
        #2;
    endtask

    task automatic do_reset();
        rst_gtp_n = 1'b0;
        tick(2);
        rst_gtp_n = 1'b1;
        tick();
    endtask

    task automatic wait_strb(input string tag, input int target, input int limit);
        int t = 0;
        while (sq.size() < target && t < limit) begin tick(); t++; end
        chk({tag, "_strb_wait"}, 32'(sq.size() >= target), 32'd1);
    endtask

    task automatic chk_pkt(input string tag, input int s0, input int w0, input int v, input int n);
        logic [2:0] exp_deq;
        exp_deq = 3'b001 << v;
        chk({tag, "_nstrb"}, 32'(sq.size() >= s0 + n), 32'd1);
        chk({tag, "_nword"}, 32'(wq.size() >= w0 + n + 1), 32'd1);
        if (sq.size() < s0 + n || wq.size() < w0 + n + 1) return;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_deq%0d", tag, k),  32'(sq[s0+k].deq), 32'(exp_deq));
            chk($sformatf("%s_off%0d", tag, k),  32'(sq[s0+k].off), 32'(k));
            chk($sformatf("%s_xeop%0d", tag, k), 32'(sq[s0+k].eop), 32'(k == n - 1));
            if (k > 0) chk($sformatf("%s_scyc%0d", tag, k), 32'(sq[s0+k].cyc), 32'(sq[s0].cyc + k));
        end
        for (int k = 0; k <= n; k++) begin
            chk($sformatf("%s_sop%0d", tag, k),  32'(wq[w0+k].sop), 32'(k == 0));
            chk($sformatf("%s_eop%0d", tag, k),  32'(wq[w0+k].eop), 32'(k == n));
            chk($sformatf("%s_dat%0d", tag, k),  32'(wq[w0+k].data),
                32'((k < n) ? mem[v][k] : crc_ref(v, n)));
            chk($sformatf("%s_wcyc%0d", tag, k), 32'(wq[w0+k].cyc), 32'(sq[s0].cyc + 2 + k));
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({o_xbi_nin_deq, o_xbi_nin_offset, o_xbi_nin_eop, o_gtp_out_valid,
                    o_gtp_out_sop, o_gtp_out_eop, o_gtp_out_data, o_error_credit, o_error_len});
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, w0, c, e0, s1;
        int gv[$];
        int exp_rr[4];
`ifdef GTP_NIN_SCHED_PRIO_EN
        exp_rr = '{2, 2, 2, 2};
`else
        exp_rr = '{0, 1, 2, 0};
`endif
        for (int v = 0; v < 3; v++)
            for (int k = 0; k < 64; k++)
                mem[v][k] = 16'(((v + 1) * 16'h1111) ^ (k * 16'h0203));
        mem[0][0] = 16'h0040; mem[0][1] = 16'h0001; mem[0][2] = 16'h0002; mem[0][3] = 16'h0003;
        for (int v = 0; v < 3; v++) len_v[v] = 6'd0;
        i_xbi_nin_ready  = 3'b000;
        i_gtp_out_hold   = 1'b0;
        i_gtp_out_credit = 3'b000;
        rst_gtp_n = 1'b1;
        #1 rst_gtp_n = 1'b0;

        // reset state and a single 4-word VC0 packet
        tick(2);
        chk("rst_outs", outs_vec(), 32'd0);
        rst_gtp_n = 1'b1;
        tick();
        s0 = sq.size(); w0 = wq.size(); c = cyc;
        len_v[0] = 6'd4; i_xbi_nin_ready = 3'b001;
        wait_strb("t1", s0 + 1, 10);
        i_xbi_nin_ready = 3'b000;
        if (sq.size() > s0) chk("t1_lat", 32'(sq[s0].cyc), 32'(c + 1));
        tick(12);
        chk_pkt("t1", s0, w0, 0, 4);
        chk("t1_only_one", 32'(sq.size() - s0), 32'd4);

        // all VCs ready, credit returned after each packet
        do_reset();
        for (int v = 0; v < 3; v++) len_v[v] = 6'd2;
        s0 = sq.size(); w0 = wq.size();
        i_xbi_nin_ready = 3'b111;
        for (int i = 0; i < 40; i++) begin
            tick();
            i_gtp_out_credit = o_xbi_nin_eop ? o_xbi_nin_deq : 3'b000;
        end
        i_xbi_nin_ready = 3'b000; i_gtp_out_credit = 3'b000;
        tick(10);
        for (int i = s0; i < sq.size(); i++) if (sq[i].off == 6'd0) gv.push_back(vc_of(sq[i].deq));
        chk("rr_have4", 32'(gv.size() >= 4), 32'd1);
        if (gv.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("rr_vc%0d", i), 32'(gv[i]), 32'(exp_rr[i]));
                chk_pkt($sformatf("rr%0d", i), s0 + 2 * i, w0 + 3 * i, exp_rr[i], 2);
            end
            for (int i = 0; i < 3; i++)
                chk($sformatf("rr_gap%0d", i), 32'(wq[w0+3*i+3].cyc - wq[w0+3*i+2].cyc), 32'd3);
        end

        // credit exhaustion on VC1, then a returned credit
        do_reset();
        len_v[1] = 6'd3; i_xbi_nin_ready = 3'b010;
        s0 = sq.size();
        tick(30);
        chk("cr_vc1_two", 32'(ngrants(s0)), 32'd2);
        s1 = sq.size(); c = cyc;
        i_gtp_out_credit = 3'b010;
        tick();
        i_gtp_out_credit = 3'b000;
        wait_strb("cr_ret", s1 + 1, 10);
        i_xbi_nin_ready = 3'b000;
        if (sq.size() > s1) chk("cr_ret_lat", 32'(sq[s1].cyc), 32'(c + 2));
        tick(10);
        chk("cr_vc1_three", 32'(ngrants(s0)), 32'd3);

        // credit overflow on VC2
        e0 = ecred_n; c = cyc;
        i_gtp_out_credit = 3'b100;
        tick();
        i_gtp_out_credit = 3'b000;
        tick(3);
        chk("ov_pulses", 32'(ecred_n - e0), 32'd1);
        chk("ov_cyc", 32'(ecred_cyc), 32'(c + 1));
        len_v[2] = 6'd1; i_xbi_nin_ready = 3'b100;
        s0 = sq.size();
        tick(30);
        i_xbi_nin_ready = 3'b000;
        chk("ov_vc2_sat", 32'(ngrants(s0)), 32'd2);

        // grant and credit pulse on VC0 in the same cycle
        tick(5);
        e0 = ecred_n; s0 = sq.size();
        len_v[0] = 6'd1; i_xbi_nin_ready = 3'b001; i_gtp_out_credit = 3'b001;
        tick();
        i_gtp_out_credit = 3'b000;
        tick(40);
        i_xbi_nin_ready = 3'b000;
        chk("same_vc0_grants", 32'(ngrants(s0)), 32'd3);
        chk("same_no_err", 32'(ecred_n - e0), 32'd0);

        // hold in IDLE blocks grants; hold during RD does not stop the packet
        do_reset();
        len_v[0] = 6'd5; i_gtp_out_hold = 1'b1; i_xbi_nin_ready = 3'b001;
        s0 = sq.size(); w0 = wq.size();
        tick(8);
        chk("hold_nogrant", 32'(sq.size() - s0), 32'd0);
        c = cyc; i_gtp_out_hold = 1'b0;
        wait_strb("hold1", s0 + 1, 5);
        if (sq.size() > s0) chk("hold1_lat", 32'(sq[s0].cyc), 32'(c + 1));
        i_gtp_out_hold = 1'b1;
        tick(12);
        chk_pkt("hold1", s0, w0, 0, 5);
        tick(10);
        chk("hold_blocks", 32'(sq.size() - s0), 32'd5);
        c = cyc; i_gtp_out_hold = 1'b0;
        wait_strb("hold2", s0 + 6, 5);
        i_xbi_nin_ready = 3'b000;
        if (sq.size() > s0 + 5) chk("hold2_lat", 32'(sq[s0+5].cyc), 32'(c + 1));
        tick(12);

        // zero-length packet
        len_v[1] = 6'd0; i_xbi_nin_ready = 3'b010;
        e0 = elen_n; s0 = sq.size(); w0 = wq.size(); c = cyc;
        wait_strb("len0", s0 + 1, 5);
        i_xbi_nin_ready = 3'b000;
        tick(8);
        chk_pkt("len0", s0, w0, 1, 1);
        chk("len0_err_n", 32'(elen_n - e0), 32'd1);
        chk("len0_err_cyc", 32'(elen_cyc), 32'(c + 1));
        chk("len0_nstrb", 32'(sq.size() - s0), 32'd1);

        // reset in the middle of a packet
        do_reset();
        len_v[1] = 6'd8; i_xbi_nin_ready = 3'b010;
        s0 = sq.size();
        wait_strb("mid", s0 + 1, 5);
        i_xbi_nin_ready = 3'b000;
        tick(3);
        chk("mid_busy", 32'(o_gtp_out_valid), 32'd1);
        rst_gtp_n = 1'b0;
        #1;
        chk("mid_async", outs_vec(), 32'd0);
        tick(2);
        rst_gtp_n = 1'b1;
        tick();
        len_v[0] = 6'd1; len_v[2] = 6'd1; i_xbi_nin_ready = 3'b101;
        s0 = sq.size();
        wait_strb("post", s0 + 1, 5);
        i_xbi_nin_ready = 3'b000;
`ifdef GTP_NIN_SCHED_PRIO_EN
        if (sq.size() > s0) chk("post_first", 32'(sq[s0].deq), 32'h4);
`else
        if (sq.size() > s0) chk("post_first", 32'(sq[s0].deq), 32'h1);
`endif
        tick(10);
        len_v[1] = 6'd1; i_xbi_nin_ready = 3'b010;
        s0 = sq.size();
        tick(30);
        i_xbi_nin_ready = 3'b000;
        chk("post_vc1_cred", 32'(ngrants(s0)), 32'd2);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
